// File: rtl/usr_pkg.sv
// usr_pkg: USR select encodings and sequencer FSM state type shared by usr_shift_sequencer
package usr_pkg;
  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } usr_seq_state_t;
endpackage

// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: drives a parent USR as a full-duplex serial engine; tx_*/rx_* valid-ready words in/out, ser_in/ser_out serial pins, usr_* USR controls; USR_SEQ_LOOPBACK_EN adds a loopback input that rotates the word instead of receiving ser_in
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_dir,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_parallel_in,
  output logic             usr_serial_rightin,
  output logic             usr_serial_leftin,
  input  logic             usr_serial_rightout,
  input  logic             usr_serial_leftout,
`ifdef USR_SEQ_LOOPBACK_EN
  input  logic             loopback,
`endif
  input  logic [WIDTH-1:0] usr_parallel_out
);
  localparam int CW = $clog2(WIDTH);
  usr_seq_state_t state;
  logic [WIDTH-1:0] word;
  logic dir;
  logic [CW-1:0] cnt;
  logic shifting;
  logic rx_bit;
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state <= ST_IDLE;
      word  <= '0;
      dir   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (tx_valid) begin
          word  <= tx_data;
          dir   <= tx_dir;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          cnt   <= CW'(WIDTH - 1);
          state <= ST_SHIFT;
        end
        ST_SHIFT: if (cnt == '0) state <= ST_DONE; else cnt <= cnt - CW'(1);
        ST_DONE: if (rx_ready) state <= ST_IDLE;
      endcase
    end
  end
  assign shifting        = state == ST_SHIFT;
  assign tx_ready        = state == ST_IDLE;
  assign rx_valid        = state == ST_DONE;
  assign ser_out_valid   = shifting;
  assign rx_data         = usr_parallel_out;
  assign usr_parallel_in = word;
  assign usr_select      = state == ST_LOAD ? USR_LOAD : shifting ? (dir ? USR_SHL : USR_SHR) : USR_HOLD;
  assign ser_out         = dir ? usr_serial_leftout : usr_serial_rightout;
`ifdef USR_SEQ_LOOPBACK_EN
  assign rx_bit = loopback ? ser_out : ser_in;
`else
  assign rx_bit = ser_in;
`endif
  assign usr_serial_rightin = shifting && !dir ? rx_bit : 1'b0;
  assign usr_serial_leftin  = shifting && dir ? rx_bit : 1'b0;
endmodule

// File: tb/tb_usr_shift_sequencer.sv
// tb_usr_shift_sequencer: directed self-checking bench with a bench-side USR and a transfer-timeline model of the sequencer
module tb_usr_shift_sequencer;
  import usr_pkg::*;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic tx_valid = 1'b0;
  logic tx_dir = 1'b0;
  logic rx_ready = 1'b0;
  logic ser_in = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_ready, rx_valid, ser_out, ser_out_valid, usr_serial_rightin, usr_serial_leftin;
  logic [1:0] usr_select;
  logic [W-1:0] rx_data, usr_parallel_in;
  logic [W-1:0] q = '0;
  logic lb;
  int checks = 0;
  int errors = 0;
`ifdef USR_SEQ_LOOPBACK_EN
  logic loopback = 1'b0;
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif
  usr_shift_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .rstN(rstN),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data(tx_data),
    .tx_dir(tx_dir),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .ser_in(ser_in),
    .ser_out(ser_out),
    .ser_out_valid(ser_out_valid),
    .usr_select(usr_select),
    .usr_parallel_in(usr_parallel_in),
    .usr_serial_rightin(usr_serial_rightin),
    .usr_serial_leftin(usr_serial_leftin),
    .usr_serial_rightout(q[0]),
    .usr_serial_leftout(q[W-1]),
`ifdef USR_SEQ_LOOPBACK_EN
    .loopback(loopback),
`endif
    .usr_parallel_out(q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    case (usr_select)
      2'b01: q <= {usr_serial_rightin, q[W-1:1]};
      2'b10: q <= {q[W-2:0], usr_serial_leftin};
      2'b11: q <= usr_parallel_in;
      default: ;
    endcase
  end
  int ph = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] m_rx = '0;
  logic m_dir = 1'b0;
  logic started = 1'b0;
  function automatic int bidx(int k);
    return m_dir ? W - 1 - k : k;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    if (!rstN) begin
      ph <= 0;
      m_word <= '0;
      m_dir <= 1'b0;
      started <= 1'b1;
    end else if (ph == 0) begin
      if (tx_valid) begin
        ph <= 1;
        m_word <= tx_data;
        m_dir <= tx_dir;
      end
    end else if (ph <= W + 1) begin
      ph <= ph + 1;
      if (ph >= 2) m_rx[bidx(ph-2)] <= lb ? m_word[bidx(ph-2)] : ser_in;
    end else if (rx_ready) ph <= 0;
  end
  always @(negedge clk) begin
    if (started) begin
      automatic logic sh = ph >= 2 && ph <= W + 1;
      automatic logic [1:0] esel = ph == 1 ? 2'b11 : sh ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
      automatic logic ebit = lb ? (m_dir ? q[W-1] : q[0]) : ser_in;
      chk("tx_ready", tx_ready, ph == 0);
      chk("rx_valid", rx_valid, ph == W + 2);
      chk("ser_out_valid", ser_out_valid, sh);
      chk("usr_select", usr_select, esel);
      chk("usr_parallel_in", usr_parallel_in, m_word);
      chk("serial_rightin", usr_serial_rightin, sh && !m_dir ? ebit : 1'b0);
      chk("serial_leftin", usr_serial_leftin, sh && m_dir ? ebit : 1'b0);
      if (sh) chk("ser_out", ser_out, m_word[bidx(ph-2)]);
      if (ph == W + 2) chk("rx_data_model", rx_data, m_rx);
    end
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic [W-1:0] w, input logic d, input logic [W-1:0] s,
                      input logic [W-1:0] exp_out, input logic [W-1:0] exp_rx, input int hold);
    int n;
    int k;
    logic [W-1:0] got;
    logic [W-1:0] held;
    got = '0;
    k = 0;
    tx_data = w;
    tx_dir = d;
    tx_valid = 1'b1;
    rx_ready = 1'b0;
    cyc;
    tx_valid = 1'b0;
    n = 1;
    while (!rx_valid && n < 20) begin
      if (ser_out_valid && k < W) begin
        ser_in = s[k];
        got[W-1-k] = ser_out;
        k++;
      end
      cyc;
      n++;
    end
    chk("rx_latency", n, 6);
    chk("ser_out_seq", got, exp_out);
    chk("rx_data", rx_data, exp_rx);
    held = rx_data;
    for (int i = 0; i < hold; i++) begin
      tx_valid = 1'b1;
      tx_data = ~w;
      cyc;
      chk("bp_rx_valid", rx_valid, 1'b1);
      chk("bp_rx_stable", rx_data, held);
      chk("bp_select", usr_select, 2'b00);
      chk("bp_tx_ready", tx_ready, 1'b0);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    cyc;
    rx_ready = 1'b0;
    chk("back_idle", tx_ready, 1'b1);
  endtask
  initial begin
    cyc;
    cyc;
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_select", usr_select, 2'b00);
    chk("rst_ser_out_valid", ser_out_valid, 1'b0);
    chk("rst_parallel_in", usr_parallel_in, 4'b0000);
    rstN = 1'b1;
    cyc;
    xfer(4'b1101, 1'b0, 4'b0110, 4'b1011, 4'b0110, 0);
    xfer(4'b1100, 1'b1, 4'b1001, 4'b1100, 4'b1001, 0);
    xfer(4'b1010, 1'b0, 4'b0011, 4'b0101, 4'b0011, 3);
    tx_data = 4'b1111;
    tx_dir = 1'b0;
    tx_valid = 1'b1;
    cyc;
    tx_valid = 1'b0;
    cyc;
    ser_in = 1'b1;
    cyc;
    cyc;
    chk("mid_in_shift", ser_out_valid, 1'b1);
    rstN = 1'b0;
    cyc;
    rstN = 1'b1;
    chk("mid_rst_tx_ready", tx_ready, 1'b1);
    chk("mid_rst_select", usr_select, 2'b00);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc;
      chk("mid_rst_no_rx", rx_valid, 1'b0);
    end
    xfer(4'b0110, 1'b1, 4'b0101, 4'b0110, 4'b1010, 0);
`ifdef USR_SEQ_LOOPBACK_EN
    loopback = 1'b1;
    xfer(4'b1011, 1'b0, 4'b0000, 4'b1101, 4'b1011, 0);
    xfer(4'b1011, 1'b1, 4'b1111, 4'b1011, 4'b1011, 0);
    loopback = 1'b0;
`endif
    cyc;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
